// File: rtl/dpe_pcapmux.sv
// dpe_pcapmux: round-robin, packet-atomic merge of NUM_CH AXI-Stream taps into one tagged stream,
// with per-channel packet/byte counters and an optional rotating ready-throttle mask.
module dpe_pcapmux #(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH = 32,
  parameter int THROTTLE_EN = 0,
  parameter logic [15:0] THROTTLE_PATTERN = 16'hFFFF,
  localparam int KW = DATA_WIDTH / 8,
  localparam int IDW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  s_tdata,
  input  logic [NUM_CH*KW-1:0]          s_tkeep,
  input  logic [NUM_CH-1:0]             s_tvalid,
  input  logic [NUM_CH-1:0]             s_tlast,
  output logic [NUM_CH-1:0]             s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic [KW-1:0]                 m_tkeep,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  output logic [IDW-1:0]                m_tid,
  input  logic                          m_tready,
  output logic [NUM_CH*CNT_WIDTH-1:0]   pkt_count,
  output logic [NUM_CH*CNT_WIDTH-1:0]   byte_count
);
  localparam int PW = $clog2(KW + 1);

  typedef enum logic {IDLE, PASS} state_t;

  state_t r_state, w_next;
  logic [IDW-1:0] r_ptr, r_grant, w_sel, w_gnext;
  logic [15:0] r_thr;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] r_pkt, r_byte;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_data;
  logic [NUM_CH-1:0][KW-1:0] w_keep;
  logic [NUM_CH-1:0] w_rdy;
  logic [PW-1:0] w_pop;
  logic w_allow, w_pass, w_acc;

  assign w_data = s_tdata;
  assign w_keep = s_tkeep;
  assign w_allow = THROTTLE_EN != 0 ? r_thr[0] : 1'b1;
  assign w_pass = r_state == PASS;
  assign m_tdata = w_data[r_grant];
  assign m_tkeep = w_keep[r_grant];
  assign m_tlast = s_tlast[r_grant];
  assign m_tvalid = w_pass & s_tvalid[r_grant] & w_allow;
  assign m_tid = r_grant;
  assign w_acc = m_tvalid & m_tready;
  assign w_gnext = r_grant == IDW'(NUM_CH - 1) ? '0 : r_grant + 1'b1;
  assign s_tready = w_rdy;
  assign pkt_count = r_pkt;
  assign byte_count = r_byte;

  // Scan from the highest index down so the channel closest to r_ptr wins last.
  always_comb begin
    w_sel = r_ptr;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (s_tvalid[IDW'((int'(r_ptr) + i) % NUM_CH)]) w_sel = IDW'((int'(r_ptr) + i) % NUM_CH);
  end

  always_comb begin
    w_rdy = '0;
    w_rdy[r_grant] = w_pass & m_tready & w_allow;
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < KW; i++) w_pop = w_pop + PW'(m_tkeep[i]);
  end

  always_comb begin
    w_next = w_pass ? (w_acc && m_tlast ? IDLE : PASS) : (|s_tvalid ? PASS : IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_grant <= '0;
      r_thr <= THROTTLE_PATTERN;
      r_pkt <= '0;
      r_byte <= '0;
    end else begin
      r_state <= w_next;
      r_thr <= {r_thr[0], r_thr[15:1]};
      if (!w_pass && |s_tvalid) r_grant <= w_sel;
      if (w_acc) r_byte[r_grant] <= r_byte[r_grant] + CNT_WIDTH'(w_pop);
      if (w_acc && m_tlast) begin
        r_pkt[r_grant] <= r_pkt[r_grant] + 1'b1;
        r_ptr <= w_gnext;
      end
    end
  end
endmodule

// File: tb/tb_dpe_pcapmux.sv
// tb_dpe_pcapmux: scoreboard bench for dpe_pcapmux; a 4-channel instance with 8-bit counters
// plus a 2-channel throttled instance driven from the same clock and reset.
module tb_dpe_pcapmux;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4*128-1:0] s_tdata;
  logic [4*16-1:0] s_tkeep;
  logic [3:0] s_tvalid, s_tlast, s_tready;
  logic [127:0] m_tdata;
  logic [15:0] m_tkeep;
  logic m_tvalid, m_tlast, m_tready;
  logic [1:0] m_tid;
  logic [31:0] pkt_count, byte_count;

  logic [63:0] t_s_tdata;
  logic [7:0] t_s_tkeep;
  logic [1:0] t_s_tvalid, t_s_tlast, t_s_tready;
  logic [31:0] t_m_tdata;
  logic [3:0] t_m_tkeep;
  logic t_m_tvalid, t_m_tlast, t_m_tready;
  logic [0:0] t_m_tid;
  logic [31:0] t_pkt, t_byte;

  dpe_pcapmux #(.NUM_CH(4), .DATA_WIDTH(128), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tid(m_tid), .m_tready(m_tready),
    .pkt_count(pkt_count), .byte_count(byte_count));

  dpe_pcapmux #(.NUM_CH(2), .DATA_WIDTH(32), .CNT_WIDTH(16), .THROTTLE_EN(1),
                .THROTTLE_PATTERN(16'hAAAA)) u_thr (
    .clk(clk), .rst(rst), .s_tdata(t_s_tdata), .s_tkeep(t_s_tkeep), .s_tvalid(t_s_tvalid),
    .s_tlast(t_s_tlast), .s_tready(t_s_tready), .m_tdata(t_m_tdata), .m_tkeep(t_m_tkeep),
    .m_tvalid(t_m_tvalid), .m_tlast(t_m_tlast), .m_tid(t_m_tid), .m_tready(t_m_tready),
    .pkt_count(t_pkt), .byte_count(t_byte));

  typedef struct packed {logic [127:0] d; logic [15:0] k; logic l;} beat_t;
  typedef struct packed {logic [3:0] mask; logic [3:0][1:0] ord;} rr_t;

  beat_t q[4][$];
  logic [32:0] tq[$];
  bit rdy_pat[$];
  int order[$];
  int exp_pkt[4], exp_byte[4];
  int checks = 0, errors = 0, cyc = 0, nacc = 0, nstall = 0, since_end = 99, mptr = 0;
  int tfirst = -1, tlast = 0, tn = 0;
  bit in_pkt = 0, want = 0, rnd_rdy = 0;
  rr_t tbl[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit any_pending();
    for (int c = 0; c < 4; c++) if (q[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_pkt(input int c, input int n);
    for (int i = 0; i < n; i++) q[c].push_back('{d: rnd128(), k: 16'($urandom()), l: i == n - 1});
  endtask

  task automatic drive();
    for (int c = 0; c < 4; c++) begin
      s_tvalid[c] = q[c].size() != 0;
      s_tdata[c*128 +: 128] = q[c].size() != 0 ? q[c][0].d : '0;
      s_tkeep[c*16 +: 16] = q[c].size() != 0 ? q[c][0].k : '0;
      s_tlast[c] = q[c].size() != 0 ? q[c][0].l : 1'b0;
    end
    m_tready = rdy_pat.size() != 0 ? rdy_pat.pop_front() : (rnd_rdy ? $urandom_range(0, 3) != 0 : 1'b1);
    t_s_tvalid = {1'b0, tq.size() != 0};
    t_s_tdata = {32'h0, tq.size() != 0 ? tq[0][31:0] : 32'h0};
    t_s_tlast = {1'b0, tq.size() != 0 ? tq[0][32] : 1'b0};
    t_s_tkeep = 8'h0F;
    t_m_tready = 1'b1;
  endtask

  task automatic tick_sample();
    beat_t b;
    int e;
    @(negedge clk);
    cyc++;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("pkt_count[%0d]", c), 128'(pkt_count[c*8 +: 8]), 128'(exp_pkt[c] % 256));
      chk($sformatf("byte_count[%0d]", c), 128'(byte_count[c*8 +: 8]), 128'(exp_byte[c] % 256));
    end
    chk("s_tready_other", 128'(s_tready & ~(4'b1 << m_tid)), 128'(0));
    chk("s_tready_grant", 128'(s_tready[m_tid]), 128'(m_tvalid & m_tready));
    if (since_end < 99) since_end++;
    if (since_end == 1) begin
      chk("gap_idle", 128'(m_tvalid), 128'(0));
      want = any_pending();
    end
    if (since_end == 2 && want) chk("gap_resume", 128'(m_tvalid), 128'(1));
    if (m_tvalid) begin
      if (q[m_tid].size() == 0) chk("valid_without_data", 128'(1), 128'(0));
      else begin
        b = q[m_tid][0];
        if (!in_pkt) begin
          e = mptr;
          for (int i = 0; i < 4; i++)
            if (q[(mptr + i) % 4].size() != 0) begin
              e = (mptr + i) % 4;
              break;
            end
          chk("rr_tid", 128'(m_tid), 128'(e));
          in_pkt = 1;
          order.push_back(int'(m_tid));
        end
        chk("m_tdata", m_tdata, b.d);
        chk("m_tkeep", 128'(m_tkeep), 128'(b.k));
        chk("m_tlast", 128'(m_tlast), 128'(b.l));
        if (m_tready) begin
          void'(q[m_tid].pop_front());
          nacc++;
          exp_byte[m_tid] += $countones(b.k);
          if (b.l) begin
            exp_pkt[m_tid]++;
            mptr = (int'(m_tid) + 1) % 4;
            in_pkt = 0;
            since_end = 0;
          end
        end else nstall++;
      end
    end
    chk("thr_sready", 128'(t_s_tready), 128'({1'b0, t_m_tvalid & t_m_tready}));
    if (t_m_tvalid && t_m_tready) begin
      if (tq.size() == 0) chk("thr_valid_without_data", 128'(1), 128'(0));
      else begin
        chk("thr_data", 128'(t_m_tdata), 128'(tq[0][31:0]));
        chk("thr_last", 128'(t_m_tlast), 128'(tq[0][32]));
        void'(tq.pop_front());
        if (tfirst < 0) tfirst = cyc;
        else chk("thr_interval", 128'(cyc - tlast), 128'(2));
        tlast = cyc;
        tn++;
      end
    end
  endtask

  task automatic tick_drive();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic step();
    tick_sample();
    tick_drive();
  endtask

  task automatic drain();
    int n = 0;
    while ((any_pending() || in_pkt || tq.size() != 0) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 128'(1), 128'(0));
    repeat (2) step();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a0, s0, n;
    tbl[0] = '{mask: 4'b1010, ord: {2'd0, 2'd0, 2'd3, 2'd1}};
    tbl[1] = '{mask: 4'b1001, ord: {2'd0, 2'd0, 2'd3, 2'd0}};
    tbl[2] = '{mask: 4'b0101, ord: {2'd0, 2'd0, 2'd2, 2'd0}};
    tbl[3] = '{mask: 4'b1111, ord: {2'd2, 2'd1, 2'd0, 2'd3}};
    tbl[4] = '{mask: 4'b0110, ord: {2'd0, 2'd0, 2'd2, 2'd1}};
    for (int c = 0; c < 4; c++) begin
      exp_pkt[c] = 0;
      exp_byte[c] = 0;
    end
    rst = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mvalid", 128'(m_tvalid), 128'(0));
    chk("reset_sready", 128'(s_tready), 128'(0));
    chk("reset_tid", 128'(m_tid), 128'(0));
    chk("reset_pkt", 128'(pkt_count), 128'(0));
    chk("reset_byte", 128'(byte_count), 128'(0));
    chk("reset_thr_mvalid", 128'(t_m_tvalid), 128'(0));
    rst = 1'b0;

    // single packet: two full beats then a half beat
    q[0].push_back('{d: rnd128(), k: 16'hFFFF, l: 1'b0});
    q[0].push_back('{d: rnd128(), k: 16'hFFFF, l: 1'b0});
    q[0].push_back('{d: rnd128(), k: 16'h00FF, l: 1'b1});
    drive();
    tick_sample();
    chk("t1_idle_cycle", 128'(m_tvalid), 128'(0));
    tick_drive();
    tick_sample();
    chk("t1_first_valid", 128'(m_tvalid), 128'(1));
    chk("t1_tid", 128'(m_tid), 128'(0));
    tick_drive();
    drain();
    chk("t1_pkt_count", 128'(pkt_count[7:0]), 128'(1));
    chk("t1_byte_count", 128'(byte_count[7:0]), 128'(40));

    // round-robin order table
    for (int i = 0; i < 5; i++) begin
      order.delete();
      for (int c = 0; c < 4; c++) if (tbl[i].mask[c]) push_pkt(c, $urandom_range(1, 3));
      drive();
      drain();
      chk($sformatf("rr_count[%0d]", i), 128'(order.size()), 128'($countones(tbl[i].mask)));
      for (int j = 0; j < $countones(tbl[i].mask); j++)
        chk($sformatf("rr_order[%0d][%0d]", i, j), 128'(order.size() > j ? order[j] : 99),
            128'(tbl[i].ord[j]));
    end

    // backpressure on a 4-beat ch2 packet
    a0 = nacc;
    s0 = nstall;
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    push_pkt(2, 4);
    drive();
    drain();
    chk("t3_stalls", 128'(nstall - s0), 128'(2));
    chk("t3_beats", 128'(nacc - a0), 128'(4));

    // randomized multi-channel traffic with random m_tready
    rnd_rdy = 1;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 4; c++) repeat ($urandom_range(0, 3)) push_pkt(c, $urandom_range(1, 4));
      drive();
      drain();
    end
    rnd_rdy = 0;

    // throttle instance: 8-beat packet, one transfer every second cycle
    for (int i = 0; i < 8; i++) tq.push_back({i == 7, $urandom()});
    drive();
    drain();
    chk("t4_beats", 128'(tn), 128'(8));
    chk("t4_span", 128'(tlast - tfirst), 128'(14));
    chk("t4_pkt", 128'(t_pkt[15:0]), 128'(1));
    chk("t4_bytes", 128'(t_byte[15:0]), 128'(32));

    // reset while beat 2 of 5 is on ch1
    a0 = nacc;
    push_pkt(1, 5);
    drive();
    n = 0;
    while (nacc - a0 < 1 && n < 50) begin
      step();
      n++;
    end
    chk("t5_first_beat", 128'(nacc - a0), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("t5_mvalid", 128'(m_tvalid), 128'(0));
    chk("t5_sready", 128'(s_tready), 128'(0));
    chk("t5_pkt", 128'(pkt_count), 128'(0));
    chk("t5_byte", 128'(byte_count), 128'(0));
    chk("t5_tid", 128'(m_tid), 128'(0));
    chk("t5_thr_pkt", 128'(t_pkt), 128'(0));
    for (int c = 0; c < 4; c++) begin
      q[c].delete();
      exp_pkt[c] = 0;
      exp_byte[c] = 0;
    end
    mptr = 0;
    in_pkt = 0;
    since_end = 99;
    drive();
    @(posedge clk);
    #1 rst = 1'b0;
    push_pkt(1, 5);
    drive();
    drain();
    chk("t5_after_pkt", 128'(pkt_count[15:8]), 128'(1));

    // 256 one-beat packets wrap the 8-bit packet counter
    for (int i = 0; i < 256; i++) q[0].push_back('{d: rnd128(), k: 16'($urandom()), l: 1'b1});
    drive();
    drain();
    chk("t6_pkt_wrap", 128'(pkt_count[7:0]), 128'(0));
    chk("t6_no_x", 128'($isunknown({m_tdata, m_tkeep, m_tvalid, m_tlast, m_tid, s_tready,
                                    pkt_count, byte_count})), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
